// File: rtl/mos6502s_pkg.sv
// Shared encodings for the mos6502s core: stack op codes, stack page and
// stack sequencer states.
package mos6502s_pkg;

    localparam logic       STK_PUSH   = 1'b0;
    localparam logic       STK_PULL   = 1'b1;
    localparam logic [7:0] STACK_PAGE = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        PULL,
        PULL_TAIL,
        DONE
    } stk_state_t;

endpackage

// File: rtl/mos6502s_stack_sequencer.sv
// Multi-byte page-1 stack push/pull sequencer; drives the stack pointer's
// inc/dec strobes and repacks pulled bytes so pull order mirrors push order.
module mos6502s_stack_sequencer
    import mos6502s_pkg::*;
#(
    parameter int MAX_BYTES = 3,
    parameter int CNT_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [CNT_W-1:0]       req_count,
    input  logic [8*MAX_BYTES-1:0] push_data,
    input  logic [7:0]             sp_in,
    output logic                   sp_inc,
    output logic                   sp_dec,
    output logic [15:0]            mem_addr,
    output logic                   mem_we,
    output logic [7:0]             mem_wdata,
    output logic                   mem_re,
    input  logic [7:0]             mem_rdata,
    output logic [8*MAX_BYTES-1:0] pull_data,
    output logic                   done
);

    stk_state_t                  state, state_nxt;
    logic [CNT_W-1:0]            idx, idx_nxt;
    logic [CNT_W-1:0]            cidx;
    logic [CNT_W-1:0]            count_c;
    logic                        rd_pend;
    logic                        accept;
    logic [MAX_BYTES-1:0][7:0]   data_q;
    logic [MAX_BYTES-1:0][7:0]   pull_q;
    logic [7:0]                  sp_plus1;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] wide;
        wide = {1'b0, c};
        if (wide > (CNT_W+1)'(MAX_BYTES))
            return CNT_W'(MAX_BYTES);
        return c;
    endfunction

    assign count_c   = clamp_count(req_count);
    assign accept    = (state == IDLE) && req_valid;
    assign sp_plus1  = sp_in + 8'd1;
    assign pull_data = pull_q;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        req_ready = 1'b0;
        done      = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'h00;
        mem_addr  = {STACK_PAGE, sp_in};
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (count_c == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = (req_op == STK_PULL) ? PULL : PUSH;
                        idx_nxt   = count_c - CNT_W'(1);
                    end
                end
            end
            // SP points at the next free slot: write there, then decrement
            PUSH: begin
                mem_we    = 1'b1;
                mem_wdata = data_q[idx];
                sp_dec    = 1'b1;
                if (idx == '0) state_nxt = DONE;
                else           idx_nxt   = idx - CNT_W'(1);
            end
            // Pull reads one above SP; the 8-bit add keeps us inside page 1
            PULL: begin
                mem_re   = 1'b1;
                mem_addr = {STACK_PAGE, sp_plus1};
                sp_inc   = 1'b1;
                if (idx == '0) state_nxt = PULL_TAIL;
                else           idx_nxt   = idx - CNT_W'(1);
            end
            PULL_TAIL: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            cidx    <= '0;
            rd_pend <= 1'b0;
            pull_q  <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            rd_pend <= mem_re;
            // read data arrives one cycle after its strobe, so capture trails by one
            if (accept && req_op == STK_PULL && count_c != '0) begin
                pull_q <= '0;
                cidx   <= '0;
            end else if (rd_pend) begin
                pull_q[cidx] <= mem_rdata;
                cidx         <= cidx + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_q <= push_data;
    end

endmodule

// File: tb/tb_mos6502s_stack_sequencer.sv
// Directed bench for the stack sequencer with a page-1 memory and an
// external stack pointer register modelled alongside the DUT.
module tb_mos6502s_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_count;
    logic [23:0] push_data;
    logic [7:0]  sp;
    logic        sp_inc, sp_dec;
    logic [15:0] mem_addr;
    logic        mem_we, mem_re;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [23:0] pull_data;
    logic        done;

    logic        sp_ld;
    logic [7:0]  sp_ld_val;
    logic [7:0]  mem [256];

    int n_assert = 0;
    int n_fail   = 0;

    mos6502s_stack_sequencer #(.MAX_BYTES(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_count(req_count), .push_data(push_data),
        .sp_in(sp), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_rdata(mem_rdata),
        .pull_data(pull_data), .done(done)
    );

    always #5 clk = ~clk;

    // external stack pointer register and synchronous page-1 memory
    always @(posedge clk) begin
        if (sp_ld)       sp <= sp_ld_val;
        else if (sp_inc) sp <= sp + 8'd1;
        else if (sp_dec) sp <= sp - 8'd1;
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {mem_we, mem_re, sp_inc, sp_dec, done, req_ready}
    task automatic chk_strb(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, mem_we, mem_re, sp_inc, sp_dec, done, req_ready}, {26'd0, exp});
    endtask

    task automatic load_sp(input logic [7:0] v);
        sp_ld = 1'b1; sp_ld_val = v;
        tick();
        sp_ld = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_count = 2'd0;
        push_data = 24'h0; sp_ld = 1'b0; sp_ld_val = 8'h00; sp = 8'h00;
        mem_rdata = 8'h00;
        tick(); tick();
        chk_strb("reset_strobes", 6'b000001);
        chk("reset_pull_data", {8'd0, pull_data}, 32'd0);
        rst = 1'b1;

        // PUSH 3 at SP=FD
        load_sp(8'hFD);
        req_valid = 1'b1; req_op = 1'b0; req_count = 2'd3; push_data = 24'h12_34_A5;
        tick(); req_valid = 1'b0;
        chk_strb("push3_w0_strb", 6'b100100);
        chk("push3_w0", {mem_addr, 8'd0, mem_wdata}, {16'h01FD, 8'd0, 8'h12});
        tick();
        chk_strb("push3_w1_strb", 6'b100100);
        chk("push3_w1", {mem_addr, 8'd0, mem_wdata}, {16'h01FC, 8'd0, 8'h34});
        tick();
        chk_strb("push3_w2_strb", 6'b100100);
        chk("push3_w2", {mem_addr, 8'd0, mem_wdata}, {16'h01FB, 8'd0, 8'hA5});
        tick();
        chk_strb("push3_done", 6'b000010);
        chk("push3_sp", {24'd0, sp}, 32'h0000_00FA);
        tick();
        chk_strb("push3_idle", 6'b000001);

        // PULL 3 at SP=FA
        req_valid = 1'b1; req_op = 1'b1; req_count = 2'd3;
        tick(); req_valid = 1'b0;
        chk_strb("pull3_r0_strb", 6'b011000);
        chk("pull3_r0_addr", {16'd0, mem_addr}, 32'h0000_01FB);
        tick();
        chk_strb("pull3_r1_strb", 6'b011000);
        chk("pull3_r1_addr", {16'd0, mem_addr}, 32'h0000_01FC);
        tick();
        chk_strb("pull3_r2_strb", 6'b011000);
        chk("pull3_r2_addr", {16'd0, mem_addr}, 32'h0000_01FD);
        tick();
        chk_strb("pull3_tail", 6'b000000);
        tick();
        chk_strb("pull3_done", 6'b000010);
        chk("pull3_data", {8'd0, pull_data}, 32'h0012_34A5);
        chk("pull3_sp", {24'd0, sp}, 32'h0000_00FD);
        tick();
        chk_strb("pull3_idle", 6'b000001);

        // wrap: PUSH 1 at SP=00, then PULL 1
        load_sp(8'h00);
        req_valid = 1'b1; req_op = 1'b0; req_count = 2'd1; push_data = 24'h00_00_5E;
        tick(); req_valid = 1'b0;
        chk_strb("wrap_push_strb", 6'b100100);
        chk("wrap_push", {mem_addr, 8'd0, mem_wdata}, {16'h0100, 8'd0, 8'h5E});
        tick();
        chk_strb("wrap_push_done", 6'b000010);
        chk("wrap_push_sp", {24'd0, sp}, 32'h0000_00FF);
        tick();
        req_valid = 1'b1; req_op = 1'b1; req_count = 2'd1;
        tick(); req_valid = 1'b0;
        chk_strb("wrap_pull_strb", 6'b011000);
        chk("wrap_pull_addr", {16'd0, mem_addr}, 32'h0000_0100);
        tick();
        chk_strb("wrap_pull_tail", 6'b000000);
        tick();
        chk_strb("wrap_pull_done", 6'b000010);
        chk("wrap_pull_data", {8'd0, pull_data}, 32'h0000_005E);
        chk("wrap_pull_sp", {24'd0, sp}, 32'h0000_0000);
        tick();

        // count=0 pull: done next cycle, no activity, pull_data untouched
        req_valid = 1'b1; req_op = 1'b1; req_count = 2'd0;
        tick(); req_valid = 1'b0;
        chk_strb("cnt0_done", 6'b000010);
        chk("cnt0_pull_data", {8'd0, pull_data}, 32'h0000_005E);
        tick();
        chk_strb("cnt0_ready", 6'b000001);
        chk("cnt0_sp", {24'd0, sp}, 32'h0000_0000);

        // back-to-back: PULL 2 held while PUSH 2 runs
        load_sp(8'h80);
        req_valid = 1'b1; req_op = 1'b0; req_count = 2'd2; push_data = 24'hAB_77_66;
        tick();
        req_op = 1'b1; req_count = 2'd2; push_data = 24'hFF_FF_FF;
        chk_strb("b2b_w0_strb", 6'b100100);
        chk("b2b_w0", {mem_addr, 8'd0, mem_wdata}, {16'h0180, 8'd0, 8'h77});
        tick();
        chk_strb("b2b_w1_strb", 6'b100100);
        chk("b2b_w1", {mem_addr, 8'd0, mem_wdata}, {16'h017F, 8'd0, 8'h66});
        tick();
        chk_strb("b2b_done_busy", 6'b000010);
        tick();
        chk_strb("b2b_idle_accept", 6'b000001);
        tick(); req_valid = 1'b0;
        chk_strb("b2b_r0_strb", 6'b011000);
        chk("b2b_r0_addr", {16'd0, mem_addr}, 32'h0000_017F);
        tick();
        chk_strb("b2b_r1_strb", 6'b011000);
        chk("b2b_r1_addr", {16'd0, mem_addr}, 32'h0000_0180);
        tick();
        chk_strb("b2b_tail", 6'b000000);
        tick();
        chk_strb("b2b_done", 6'b000010);
        chk("b2b_pull_data", {8'd0, pull_data}, 32'h0000_7766);
        chk("b2b_sp", {24'd0, sp}, 32'h0000_0080);
        tick();

        // reset in the middle of a PUSH 3
        req_valid = 1'b1; req_op = 1'b0; req_count = 2'd3; push_data = 24'h01_02_03;
        tick(); req_valid = 1'b0;
        chk("midrst_w0", {mem_addr, 8'd0, mem_wdata}, {16'h0180, 8'd0, 8'h01});
        rst = 1'b0;
        tick();
        chk_strb("midrst_strobes", 6'b000001);
        chk("midrst_pull_data", {8'd0, pull_data}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk_strb("midrst_after", 6'b000001);
        chk("midrst_sp", {24'd0, sp}, 32'h0000_007F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mos6502s_stack_sequencer.md
Name: mos6502s_stack_sequencer

Overview:
Drives multi-byte stack pushes and pulls for the mos6502s core: PHA/PHP, JSR/RTS, and interrupt/RTI frames.
- Takes a 1–3 byte push or pull request.
- Generates page-1 memory strobes.
- Issues inc/dec strobes to the stack pointer register. It is the consumer of that register's sp output.
- Reassembles pulled bytes into a packed result and pulses done.

Parameters:
MAX_BYTES, 3, maximum bytes per request; sets width of push_data/pull_data (8*MAX_BYTES).
CNT_W, 2, width of req_count.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when req_valid & req_ready
req_op  in  1  0 = PUSH, 1 = PULL
req_count  in  CNT_W  bytes to transfer, 0..MAX_BYTES
push_data  in  8*MAX_BYTES  bytes to push, sampled at accept
sp_in  in  8  current stack pointer value
sp_inc  out  1  increment stack pointer at this edge
sp_dec  out  1  decrement stack pointer at this edge
mem_addr  out  16  stack address
mem_we  out  1  write strobe
mem_wdata  out  8  write data
mem_re  out  1  read strobe
mem_rdata  in  8  read data, valid the cycle after mem_re (synchronous memory)
pull_data  out  8*MAX_BYTES  packed pulled bytes
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE; req_ready=1.
  - sp_inc, sp_dec, mem_we, mem_re, done = 0; pull_data=0; internal byte counter=0.
  - Reset mid-operation aborts at once; stack pointer effects already issued are not undone.
- States: IDLE, PUSH, PULL, PULL_TAIL, DONE.
- IDLE:
  - req_ready=1.
  - On accept: latch op, count and push_data; byte index idx=count-1.
  - count=0 goes to DONE with no memory/SP activity.
  - Otherwise go to PUSH or PULL. For PULL, clear pull_data and set capture index cidx=0.
- PUSH, one byte per cycle:
  - mem_we=1, mem_addr={8'h01, sp_in}, mem_wdata=push_data byte[idx], sp_dec=1.
  - Bytes go out highest index first (interrupt frame: [23:16]=PCH, [15:8]=PCL, [7:0]=P).
  - idx==0 goes to DONE, else idx-1.
- PULL, one read per cycle:
  - mem_re=1, mem_addr={8'h01, sp_in+8'd1}, with the 8-bit add wrapping; sp_inc=1.
  - From the second PULL cycle onward, mem_rdata of the previous read is captured into pull_data byte[cidx], then cidx+1.
  - After the last read, go to PULL_TAIL.
- PULL_TAIL: no strobes; capture the final mem_rdata into byte[cidx]; go to DONE.
- Pull packing: first pulled byte lands in byte 0, so a 3-byte pull returns the same packing a 3-byte push consumed (RTI: byte0=P, byte1=PCL, byte2=PCH).
- DONE: done=1 for exactly one cycle; req_ready=0; go to IDLE. pull_data holds until the next PULL accept or reset.
- Latency, accept at cycle T:
  - PUSH N: writes in T+1..T+N; done at T+N+1.
  - PULL N: reads in T+1..T+N; done at T+N+2.
  - count=0: done at T+1.
- Strobes are decoded from registered state. mem_addr and mem_wdata are combinational from state and sp_in.
- sp_inc and sp_dec are never both 1. mem_we and mem_re are never both 1.
- Wrap:
  - sp_in=8'h00 during a push writes 16'h0100; the external SP then wraps to 8'hFF.
  - sp_in=8'hFF during a pull reads 16'h0100.
  - Addresses never leave page 1.
- req_valid while not IDLE is ignored (req_ready=0). The requester holds the request until accepted.
- req_count > MAX_BYTES is clamped to MAX_BYTES.

Decomposition:
- Shared package mos6502s_pkg:
  - stack op encoding (STK_PUSH=1'b0, STK_PULL=1'b1)
  - STACK_PAGE=8'h01
  - state enum {IDLE, PUSH, PULL, PULL_TAIL, DONE}
- No sub-module needed: a single FSM plus byte counters. In the core it instantiates beside mos6502s_stack_pointer, with sp_inc/sp_dec wired to that block's inc/dec inputs.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-push -> all strobes 0, done=0, req_ready=1, pull_data=0 the cycle after.
- PUSH 3 with sp=8'hFD, push_data=24'h12_34_A5:
  - writes 16'h01FD=8'h12, 16'h01FC=8'h34, 16'h01FB=8'hA5 on consecutive cycles
  - sp_dec=1 in each write cycle; final sp=8'hFA
  - done at T+4
- PULL 3 with sp=8'hFA and memory as above:
  - reads 16'h01FB, 16'h01FC, 16'h01FD
  - pull_data=24'h12_34_A5, done at T+5, final sp=8'hFD
- Wrap: PUSH 1 at sp=8'h00, data 8'h5E -> write 16'h0100, sp becomes 8'hFF. PULL 1 -> reads 16'h0100, pull_data[7:0]=8'h5E, sp=8'h00.
- count=0: accept -> no mem/sp strobes, done at T+1, req_ready=1 at T+2.
- Back-to-back: second request held with req_valid during a PUSH 2 -> not accepted until the IDLE cycle after done; no strobe overlap.
